// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - dynamic phase-shift sequencer for an ECP5 EHXPLLL
//
// Purpose:
//   Accepts one phase-shift request (output select, direction, step count)
//   and drives the PLL PHASESEL/PHASEDIR/PHASESTEP pins with fixed setup,
//   pulse-width and gap timing. It issues one PHASESTEP pulse per step, then
//   waits for PLL lock and reports completion (done) or lock timeout (done+err).
//
// Ports:
//   clk, rst              - fabric clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_sel/req_dir       - PLL output select and shift direction (1 = lag)
//   req_steps             - number of PHASESTEP pulses (0 = immediate done)
//   busy                  - controller is sequencing or waiting for lock
//   done/err              - single-cycle completion pulse, err on lock timeout
//   pll_lock              - PLL LOCK, already synchronised to clk
//   phasesel/phasedir     - held PLL select/direction pins
//   phasestep             - registered PHASESTEP pin
module pll_phase_ctrl #(
  parameter int CNT_W        = 8,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_steps,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             pll_lock,
  output logic [1:0]       phasesel,
  output logic             phasedir,
  output logic             phasestep
);

  // One shared down-counter times every phase; size it for the longest one.
  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD  = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL = (MAX_ABC > LOCK_TIMEOUT) ? MAX_ABC : LOCK_TIMEOUT;
  localparam int TMR_W   = $clog2(MAX_ALL + 1);

  // The counter is loaded with N-1 on entry so a phase lasts exactly N cycles
  // and the state advances on the cycle where the counter reads zero.
  localparam logic [TMR_W-1:0] LD_SETUP  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_PULSE  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_GAP    = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_LOCK   = TMR_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_PULSE    = 3'd2,
    S_GAP      = 3'd3,
    S_SETTLE   = 3'd4,
    S_WAITLOCK = 3'd5
  } state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [CNT_W-1:0]   steps_left, steps_d;
  logic [1:0]         sel_d;
  logic               dir_d;
  logic               done_d;
  logic               err_d;
  logic               step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      steps_left <= '0;
      phasesel   <= 2'd0;
      phasedir   <= 1'b0;
      phasestep  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      steps_left <= steps_d;
      phasesel   <= sel_d;
      phasedir   <= dir_d;
      phasestep  <= step_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    steps_d = steps_left;
    sel_d   = phasesel;
    dir_d   = phasedir;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          if (req_steps == '0) begin
            // Nothing to shift: complete at once without touching the PLL.
            done_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            tmr_d   = LD_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (tmr == '0) begin
          state_d = S_PULSE;
          tmr_d   = LD_PULSE;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end

      S_PULSE: begin
        if (tmr == '0) begin
          steps_d = steps_left - CNT_W'(1);
          state_d = S_GAP;
          tmr_d   = LD_GAP;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end

      S_GAP: begin
        if (tmr == '0) begin
          if (steps_left != '0) begin
            state_d = S_PULSE;
            tmr_d   = LD_PULSE;
          end else begin
            state_d = S_SETTLE;
            tmr_d   = LD_SETTLE;
          end
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end

      S_SETTLE: begin
        if (tmr == '0) begin
          state_d = S_WAITLOCK;
          tmr_d   = LD_LOCK;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end

      S_WAITLOCK: begin
        if (pll_lock) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmr == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // PHASESTEP is a flop that is high exactly while the FSM sits in PULSE,
    // so the pin never sees decode glitches.
    step_d = (state_d == S_PULSE);
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Dynamic phase-shift sequencer for the ECP5 `EHXPLLL` wrappers. It accepts a request: output select, direction and step count. It then drives the PLL's PHASESEL/PHASEDIR/PHASESTEP pins with guaranteed setup, pulse-width and gap timing, one PHASESTEP pulse per step. After the last step it waits for the PLL to report lock and signals completion or timeout. It sits in the fabric clock domain beside the PLL wrapper and is the only driver of that PLL's dynamic-phase pins.

## Interface
Parameters:
- `CNT_W`, 8: width of step-count field.
- `SETUP_CYC`, 2: cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP rise (≥1).
- `PULSE_CYC`, 4: PHASESTEP high time per step (≥1).
- `GAP_CYC`, 4: PHASESTEP low time after each pulse (≥1).
- `SETTLE_CYC`, 16: wait after the last gap before sampling lock (≥1).
- `LOCK_TIMEOUT`, 1024: max cycles in WAITLOCK before error (≥1).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, can accept.
- `req_sel` in 2: output select (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3).
- `req_dir` in 1: 1 = lag (PHASEDIR=1), 0 = lead.
- `req_steps` in CNT_W: number of PHASESTEP pulses (unsigned).
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, on lock timeout.
- `pll_lock` in 1: PLL LOCK, already synchronised to `clk`.
- `phasesel` out 2: to PLL PHASESEL[1:0].
- `phasedir` out 1: to PLL PHASEDIR.
- `phasestep` out 1: to PLL PHASESTEP; registered, glitch-free.

## Operation
- States: IDLE, SETUP, PULSE, GAP, SETTLE, WAITLOCK. One down-counter is shared for phase timing. A separate `steps_left` register has width CNT_W.
- IDLE: `req_ready`=1. On `req_valid`: latch sel/dir into `phasesel`/`phasedir` and load `steps_left`=`req_steps`.
  - `req_steps`≠0: go to SETUP.
  - `req_steps`=0: stay IDLE, pulse `done` next cycle, no PHASESTEP, no lock check.
- SETUP: `SETUP_CYC` cycles, then PULSE.
- PULSE: `phasestep`=1 for `PULSE_CYC` cycles. `steps_left` decrements on the last PULSE cycle. Then GAP.
- GAP: `phasestep`=0 for `GAP_CYC` cycles. Next state is PULSE if `steps_left`≠0, else SETTLE.
- SETTLE: `SETTLE_CYC` cycles, then WAITLOCK.
- WAITLOCK: each cycle, if `pll_lock`=1, go to IDLE with `done`=1 in the next cycle. Otherwise count. After `LOCK_TIMEOUT` cycles without lock, go to IDLE with `done`=1 and `err`=1.
- `phasesel`/`phasedir` change only on request acceptance. They hold their value from SETUP through the end of WAITLOCK and afterwards, until the next accept.
- `pll_lock` is ignored outside WAITLOCK. Lock loss during stepping is not an error.
- Requests are not queued. `req_valid` while busy is ignored (`req_ready`=0).

## Timing
- Reset values: `req_ready`=1, `busy`=0, `done`=0, `err`=0, `phasestep`=0, `phasesel`=0, `phasedir`=0; state IDLE, `steps_left`=0.
- Reset mid-operation: the next edge forces all of the above. A PHASESTEP pulse may be truncated. No `done` is issued.
- Timing is counted from accept in cycle 0.
  - SETUP covers cycles 1..S.
  - Pulse k (k=0..N-1) has `phasestep` high in cycles 1+S+k(P+G) .. S+k(P+G)+P.
  - WAITLOCK is entered in cycle 1+S+N(P+G)+ST.
- With lock already high, `done` is in cycle 2+S+N(P+G)+ST. With defaults and N=3, that is cycle 44.
- `req_ready` is high in the `done` cycle. A request accepted in that cycle starts normally.
- `req_steps`=2^CNT_W−1 must produce exactly that many pulses, with no wrap.
- `done`/`err` are registered single-cycle pulses. Never assert `done` twice per request.

## Test plan
- Reset, then idle: all outputs hold reset values; `req_ready`=1 for 20 cycles.
- Request sel=1, dir=1, steps=3, `pll_lock`=1: `phasesel`=1 and `phasedir`=1 from cycle 1. Exactly 3 PHASESTEP pulses, each 4 cycles high with 4-cycle gaps, first rising in cycle 3. `done` in cycle 44 only, `err`=0.
- Request steps=0: `done` in cycle 1, no PHASESTEP activity, `busy` never high.
- steps=1 with `pll_lock`=0 held: WAITLOCK lasts 1024 cycles. `done`=`err`=1 in one cycle, then IDLE.
- steps=2 with `pll_lock` low, raised 10 cycles into WAITLOCK: `done` one cycle after lock is sampled high, `err`=0. `req_valid` pulses while busy are ignored.
- `rst` asserted in the middle of the second PULSE: `phasestep`=0 and `busy`=0 on the next edge, no `done`. A new steps=1 request then completes normally.
